// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Pipeline-boundary register with a valid/ready handshake,
//             optional 2-entry skid buffer, flush-to-bubble and a
//             saturating stall counter.
//  Ports    : clk, reset (sync, active-low)
//             in_valid/in_ready/in_data/in_ctrl     upstream side
//             flush                                 kill held + incoming
//             out_valid/out_ready/out_data/out_ctrl downstream side
//             stall_cycles                          saturating stall count
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int DATA_W = 192,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Head entry (the one presented downstream)
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CTRL_W-1:0] r_out_ctrl;
    logic [CNT_W-1:0]  r_stall_cycles;

    logic w_consume;
    assign w_consume = r_out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            // Second entry that absorbs the one accepted while the head stalls.
            logic              r_skid_valid;
            logic [DATA_W-1:0] r_skid_data;
            logic [CTRL_W-1:0] r_skid_ctrl;
            // Registered copy of !skid_valid so in_ready has no path from out_ready.
            logic              r_in_ready;
            logic              w_accept;

            assign w_accept = in_valid & r_in_ready;
            assign in_ready = r_in_ready;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_out_valid  <= 1'b0;
                    r_out_data   <= '0;
                    r_out_ctrl   <= '0;
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= '0;
                    r_skid_ctrl  <= '0;
                    r_in_ready   <= 1'b1;
                end else if (flush) begin
                    // Data is kept; only valid and control are killed.
                    r_out_valid  <= 1'b0;
                    r_out_ctrl   <= '0;
                    r_skid_valid <= 1'b0;
                    r_skid_ctrl  <= '0;
                    r_in_ready   <= 1'b1;
                end else if (w_consume || !r_out_valid) begin
                    // Head slot frees up this edge.
                    if (r_skid_valid) begin
                        // Skid is older than anything upstream; in_ready is 0 so
                        // nothing can be accepted in this cycle.
                        r_out_valid  <= 1'b1;
                        r_out_data   <= r_skid_data;
                        r_out_ctrl   <= r_skid_ctrl;
                        r_skid_valid <= 1'b0;
                        r_skid_ctrl  <= '0;
                        r_in_ready   <= 1'b1;
                    end else if (w_accept) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= in_data;
                        r_out_ctrl  <= in_ctrl;
                    end else begin
                        r_out_valid <= 1'b0;
                        r_out_ctrl  <= '0;
                    end
                end else if (w_accept) begin
                    // Head is stalled: park the new entry in the skid slot.
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= in_data;
                    r_skid_ctrl  <= in_ctrl;
                    r_in_ready   <= 1'b0;
                end
            end
        end else begin : g_single
            logic w_ready;
            assign w_ready  = out_ready | ~r_out_valid;
            assign in_ready = w_ready;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                    r_out_ctrl  <= '0;
                end else if (flush) begin
                    r_out_valid <= 1'b0;
                    r_out_ctrl  <= '0;
                end else if (in_valid && w_ready) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= in_data;
                    r_out_ctrl  <= in_ctrl;
                end else if (w_consume) begin
                    r_out_valid <= 1'b0;
                    r_out_ctrl  <= '0;
                end
            end
        end
    endgenerate

    // Stall counter: only reset clears it; flush does not touch it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if (r_out_valid && !out_ready && !(&r_stall_cycles)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_ctrl     = r_out_ctrl;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Self-checking bench for pipe_stage_reg. Two instances (skid
//             and single-entry) share one stimulus stream; each has its own
//             FIFO reference model / scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NW = 4;
    localparam int SAT = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          out_ready;
    logic          flush;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    // index 0 = skid instance, index 1 = single-entry instance
    logic          ir [2];
    logic          ov [2];
    logic [DW-1:0] od [2];
    logic [CW-1:0] oc [2];
    logic [NW-1:0] st [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_skid (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_ctrl(oc[0]),
        .stall_cycles(st[0])
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_single (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_ctrl(oc[1]),
        .stall_cycles(st[1])
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    // Reference model: entries held by each stage, oldest first.
    ent_t          sb [2][$];
    logic [DW-1:0] exp_data  [2];
    int            exp_stall [2];
    bit            model_ok = 1'b0;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", name, k, act, req, $time);
        end
    endtask

    // Monitor + model: outputs are stable at the falling edge; inputs were
    // driven just after the previous rising edge.
    always @(negedge clk) begin
        int   n;
        bit   rdy;
        ent_t e;
        for (int k = 0; k < 2; k++) begin
            n   = sb[k].size();
            rdy = (k == 0) ? (n < 2) : (out_ready || n == 0);
            if (model_ok) begin
                chk("in_ready", k, {31'd0, ir[k]}, {31'd0, rdy});
                chk("out_valid", k, {31'd0, ov[k]}, {31'd0, n > 0});
                chk("out_ctrl", k, {24'd0, oc[k]}, (n > 0) ? {24'd0, sb[k][0].c} : 32'd0);
                chk("out_data", k, od[k], exp_data[k]);
                chk("stall_cycles", k, {28'd0, st[k]}, exp_stall[k]);
            end
            if (!reset) begin
                sb[k].delete();
                exp_data[k]  = '0;
                exp_stall[k] = 0;
            end else if (model_ok) begin
                if (n > 0 && !out_ready && exp_stall[k] < SAT)
                    exp_stall[k]++;
                if (ov[k] && out_ready) begin
                    chk("consume_expected", k, {31'd0, n > 0}, 32'd1);
                    if (n > 0) begin
                        e = sb[k].pop_front();
                        chk("consume_data", k, od[k], e.d);
                        chk("consume_ctrl", k, {24'd0, oc[k]}, {24'd0, e.c});
                    end
                end
                if (flush)
                    sb[k].delete();
                else if (in_valid && rdy)
                    sb[k].push_back({in_data, in_ctrl});
                if (sb[k].size() > 0)
                    exp_data[k] = sb[k][0].d;
            end
        end
        if (!reset)
            model_ok = 1'b1;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drv(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic r, input logic f);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    initial begin
        reset = 1'b0;
        drv(1'b0, '0, '0, 1'b1, 1'b0);
        cyc(3);
        reset = 1'b1;

        // Streaming at full rate; single-entry instance sees consume+accept.
        for (int i = 1; i <= 4; i++) begin
            drv(1'b1, CW'(i), 32'h100 + DW'(i), 1'b1, 1'b0);
            cyc(1);
        end
        drv(1'b1, 8'd5, 32'h105, 1'b1, 1'b0);
        cyc(1);
        drv(1'b0, '0, '0, 1'b1, 1'b0);
        cyc(2);

        // Back-pressure: A then B with downstream stalled, C held upstream.
        drv(1'b1, 8'h0A, 32'hAAAA, 1'b0, 1'b0); cyc(1);
        drv(1'b1, 8'h0B, 32'hBBBB, 1'b0, 1'b0); cyc(1);
        drv(1'b1, 8'h0C, 32'hCCCC, 1'b0, 1'b0); cyc(2);
        drv(1'b1, 8'h0C, 32'hCCCC, 1'b1, 1'b0); cyc(2);
        drv(1'b0, '0, '0, 1'b1, 1'b0);          cyc(2);

        // Flush with head and skid full.
        drv(1'b1, 8'hFF, 32'h1111, 1'b0, 1'b0); cyc(1);
        drv(1'b1, 8'hFF, 32'h2222, 1'b0, 1'b0); cyc(2);
        drv(1'b1, 8'hFF, 32'hDEAD, 1'b0, 1'b1); cyc(1);
        drv(1'b0, '0, '0, 1'b1, 1'b0);          cyc(3);

        // Counter saturation, then flush (no effect), then reset (clears).
        drv(1'b1, 8'h07, 32'h7777, 1'b0, 1'b0); cyc(1);
        drv(1'b0, '0, '0, 1'b0, 1'b0);          cyc(20);
        drv(1'b0, '0, '0, 1'b0, 1'b1);          cyc(1);
        drv(1'b0, '0, '0, 1'b0, 1'b0);          cyc(2);
        reset = 1'b0;                            cyc(1);
        reset = 1'b1;                            cyc(2);

        // Reset together with flush while both entries are valid.
        drv(1'b1, 8'h31, 32'h3131, 1'b0, 1'b0); cyc(1);
        drv(1'b1, 8'h32, 32'h3232, 1'b0, 1'b0); cyc(2);
        reset = 1'b0;
        drv(1'b1, 8'h33, 32'h3333, 1'b1, 1'b1); cyc(1);
        reset = 1'b1;
        drv(1'b0, '0, '0, 1'b1, 1'b0);          cyc(4);

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            drv(($urandom_range(9) < 7), CW'($urandom), DW'($urandom),
                ($urandom_range(9) < 6), ($urandom_range(19) == 0));
            reset = ($urandom_range(99) != 0);
            cyc(1);
        end
        reset = 1'b1;
        drv(1'b0, '0, '0, 1'b1, 1'b0);
        cyc(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
